// File: rtl/blockstacker_pkg.sv
// Shared constants and FSM state encoding for the block-stacker datapath.
package blockstacker_pkg;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned WID_W    = 8;
    localparam int unsigned BLOCK_H  = 4;
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned ROW_W    = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/block_draw_engine_if.sv
// Request/VGA signal bundle between the control side, the draw engine and the vga_adapter.
interface block_draw_engine_if;
    import blockstacker_pkg::*;

    logic                req;
    logic                req_erase;
    logic [X_W-1:0]      x_in;
    logic [Y_W-1:0]      y_in;
    logic [WID_W-1:0]    width_in;
    logic [COLOUR_W-1:0] colour_in;
    logic [COLOUR_W-1:0] bg_colour;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                busy;
    logic                done_plot;

    modport master (
        output req, req_erase, x_in, y_in, width_in, colour_in, bg_colour,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done_plot
    );

    modport slave (
        input  req, req_erase, x_in, y_in, width_in, colour_in, bg_colour,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done_plot
    );
endinterface

// File: rtl/pixel_scan_counter.sv
// Row-major column/row scan over a width x BLOCK_H block; flags the final pixel.
module pixel_scan_counter
    import blockstacker_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             enable,
    input  logic [WID_W-1:0] width,
    output logic [WID_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);
    logic last_col;
    logic last_row;

    assign last_col = (col == width - WID_W'(1));
    assign last_row = (row == ROW_W'(BLOCK_H - 1));
    assign last     = last_col && last_row;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (last_col) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + WID_W'(1);
            end
        end
    end
endmodule

// File: rtl/block_draw_engine.sv
// Rasterises one latched block onto the VGA write port, one pixel per clock,
// then holds done_plot until the requester drops req.
module block_draw_engine
    import blockstacker_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    block_draw_engine_if.slave bus
);
    localparam logic [X_W:0] X_LIMIT = (X_W + 1)'(SCREEN_W);

    state_t              state, state_next;
    logic [X_W-1:0]      x_r;
    logic [Y_W-1:0]      y_r;
    logic [WID_W-1:0]    w_r;
    logic [COLOUR_W-1:0] c_r;
    logic [WID_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic                last_px;
    logic [X_W:0]        px_sum;
    logic [X_W-1:0]      vga_x_q;
    logic [Y_W-1:0]      vga_y_q;
    logic [COLOUR_W-1:0] vga_colour_q;
    logic                vga_plot_q;

    pixel_scan_counter u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state == ST_IDLE && bus.req),
        .enable (state == ST_DRAW && bus.req),
        .width  (w_r),
        .col    (col),
        .row    (row),
        .last   (last_px)
    );

    // Extra bit so pixels past the right edge are detected rather than wrapped.
    assign px_sum = (X_W + 1)'(x_r) + (X_W + 1)'(col);

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.req) state_next = (bus.width_in == '0) ? ST_DONE : ST_DRAW;
            ST_DRAW: begin
                if (!bus.req)    state_next = ST_IDLE;
                else if (last_px) state_next = ST_DONE;
            end
            ST_DONE: if (!bus.req) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_r          <= '0;
            y_r          <= '0;
            w_r          <= '0;
            c_r          <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    vga_plot_q <= 1'b0;
                    if (bus.req) begin
                        x_r <= bus.x_in;
                        y_r <= bus.y_in;
                        w_r <= bus.width_in;
                        c_r <= bus.req_erase ? bus.bg_colour : bus.colour_in;
                    end
                end
                ST_DRAW: begin
                    if (bus.req) begin
                        vga_x_q      <= px_sum[X_W-1:0];
                        vga_y_q      <= y_r + Y_W'(row);
                        vga_colour_q <= c_r;
                        vga_plot_q   <= (px_sum < X_LIMIT);
                    end else begin
                        vga_plot_q <= 1'b0;
                    end
                end
                default: vga_plot_q <= 1'b0;
            endcase
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done_plot  = (state == ST_DONE);
endmodule

// File: tb/tb_block_draw_engine.sv
// Directed bench for block_draw_engine: inputs change and outputs are sampled on negedges.
module tb_block_draw_engine;
    logic clk = 1'b0;
    logic resetn;
    int   tests_run    = 0;
    int   tests_failed = 0;

    block_draw_engine_if bus ();

    block_draw_engine dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic issue_req(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                             input logic [2:0] c, input logic erase, input logic [2:0] bg);
        bus.x_in      = x;
        bus.y_in      = y;
        bus.width_in  = w;
        bus.colour_in = c;
        bus.req_erase = erase;
        bus.bg_colour = bg;
        bus.req       = 1'b1;
    endtask

    task automatic test_reset;
        // Plain reset state
        tests_run++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done_plot} !== '0) begin
            tests_failed++;
            $display("FAIL reset_init: outputs=%h required 0",
                     {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done_plot});
        end
        issue_req(8'd10, 7'd20, 8'd8, 3'd6, 1'b0, 3'd0);
        repeat (4) @(negedge clk);
        tests_run++;
        if (bus.vga_plot !== 1'b1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_predraw: plot=%b busy=%b required 1 1", bus.vga_plot, bus.busy);
        end
        resetn  = 1'b0;
        bus.req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done_plot} !== '0) begin
            tests_failed++;
            $display("FAIL reset_middraw: outputs=%h required 0",
                     {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done_plot});
        end
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.done_plot !== 1'b0 || bus.busy !== 1'b0 || bus.vga_plot !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_after cyc%0d: done=%b busy=%b plot=%b required 0 0 0",
                         i, bus.done_plot, bus.busy, bus.vga_plot);
            end
        end
    endtask

    task automatic test_basic_draw;
        logic [7:0] ex;
        logic [6:0] ey;
        issue_req(8'd10, 7'd20, 8'd3, 3'b101, 1'b0, 3'd0);
        @(negedge clk);
        tests_run++;
        if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_accept: plot=%b busy=%b required 0 1", bus.vga_plot, bus.busy);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ex = 8'd10 + 8'(k % 3);
            ey = 7'd20 + 7'(k / 3);
            tests_run++;
            if (bus.vga_plot !== 1'b1 || bus.vga_x !== ex || bus.vga_y !== ey ||
                bus.vga_colour !== 3'd5 || bus.done_plot !== (k == 11)) begin
                tests_failed++;
                $display("FAIL basic_px%0d: plot=%b x=%0d y=%0d c=%0d done=%b required 1 %0d %0d 5 %b",
                         k, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.done_plot,
                         ex, ey, (k == 11));
            end
        end
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (bus.vga_plot !== 1'b0 || bus.done_plot !== 1'b1 || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_done_hold: plot=%b done=%b busy=%b required 0 1 1",
                         bus.vga_plot, bus.done_plot, bus.busy);
            end
        end
        bus.req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.done_plot !== 1'b0 || bus.busy !== 1'b0 || bus.vga_x !== 8'd12 || bus.vga_y !== 7'd23) begin
            tests_failed++;
            $display("FAIL basic_release: done=%b busy=%b x=%0d y=%0d required 0 0 12 23",
                     bus.done_plot, bus.busy, bus.vga_x, bus.vga_y);
        end
    endtask

    task automatic test_erase;
        int plots = 0;
        issue_req(8'd40, 7'd60, 8'd2, 3'd7, 1'b1, 3'd0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (bus.vga_plot === 1'b1) begin
                plots++;
                tests_run++;
                if (bus.vga_colour !== 3'd0) begin
                    tests_failed++;
                    $display("FAIL erase_colour px%0d: c=%0d required 0", plots, bus.vga_colour);
                end
            end
        end
        tests_run++;
        if (plots != 8 || bus.done_plot !== 1'b1) begin
            tests_failed++;
            $display("FAIL erase_count: plots=%0d done=%b required 8 1", plots, bus.done_plot);
        end
        bus.req       = 1'b0;
        bus.req_erase = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty;
        issue_req(8'd5, 7'd5, 8'd0, 3'd2, 1'b0, 3'd0);
        @(negedge clk);
        tests_run++;
        if (bus.done_plot !== 1'b1 || bus.vga_plot !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_done: done=%b plot=%b required 1 0", bus.done_plot, bus.vga_plot);
        end
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (bus.vga_plot !== 1'b0 || bus.done_plot !== 1'b1) begin
                tests_failed++;
                $display("FAIL empty_hold: plot=%b done=%b required 0 1", bus.vga_plot, bus.done_plot);
            end
        end
        bus.req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clip_and_abort;
        logic [7:0] ex;
        logic       ep;
        issue_req(8'd158, 7'd50, 8'd4, 3'd3, 1'b0, 3'd0);
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ex = 8'd158 + 8'(k % 4);
            ep = ((158 + (k % 4)) < 160);
            tests_run++;
            if (bus.vga_plot !== ep || bus.vga_x !== ex || bus.vga_y !== 7'd50 + 7'(k / 4) ||
                bus.done_plot !== (k == 15)) begin
                tests_failed++;
                $display("FAIL clip_px%0d: plot=%b x=%0d y=%0d done=%b required %b %0d %0d %b",
                         k, bus.vga_plot, bus.vga_x, bus.vga_y, bus.done_plot,
                         ep, ex, 50 + k / 4, (k == 15));
            end
        end
        bus.req = 1'b0;
        @(negedge clk);
        // Same block again, abandoned after five pixels
        issue_req(8'd158, 7'd50, 8'd4, 3'd3, 1'b0, 3'd0);
        repeat (6) @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b0 || bus.done_plot !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort: plot=%b busy=%b done=%b required 0 0 0",
                     bus.vga_plot, bus.busy, bus.done_plot);
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.done_plot !== 1'b0 || bus.vga_plot !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort_after cyc%0d: done=%b plot=%b required 0 0",
                         i, bus.done_plot, bus.vga_plot);
            end
        end
    endtask

    task automatic test_back_to_back;
        int plots = 0;
        issue_req(8'd1, 7'd2, 8'd1, 3'd6, 1'b0, 3'd0);
        repeat (5) begin
            @(negedge clk);
            if (bus.vga_plot === 1'b1) plots++;
        end
        tests_run++;
        if (plots != 4 || bus.done_plot !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: plots=%0d done=%b required 4 1", plots, bus.done_plot);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.vga_plot !== 1'b0 || bus.done_plot !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_hold cyc%0d: plot=%b done=%b required 0 1",
                         i, bus.vga_plot, bus.done_plot);
            end
        end
        bus.req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.done_plot !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: done=%b required 0", bus.done_plot);
        end
        bus.req = 1'b1;
        plots   = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.vga_plot !== 1'b1 || bus.vga_y !== 7'd2 + 7'(k) || bus.vga_x !== 8'd1) begin
                tests_failed++;
                $display("FAIL b2b_second px%0d: plot=%b x=%0d y=%0d required 1 1 %0d",
                         k, bus.vga_plot, bus.vga_x, bus.vga_y, 2 + k);
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.done_plot !== 1'b1 || bus.vga_plot !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_done: done=%b plot=%b required 1 0", bus.done_plot, bus.vga_plot);
        end
        bus.req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.req       = 1'b0;
        bus.req_erase = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.width_in  = '0;
        bus.colour_in = '0;
        bus.bg_colour = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_draw();
        test_erase();
        test_empty();
        test_clip_and_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
